pipe_stage_elastic: RTL and testbench

Parametrised pipeline stage register, successor to the fixed-payload stage registers between core stages. Carries one opaque payload of DATA_W bits with a valid/ready handshake instead of a global hold. Adds an optional 2-entry skid buffer so upstream ready is registered, plus synchronous flush. Intended to be instantiated between any two core stages, with the stage-specific fields packed into in_data.

---
 rtl/pipe_stage_elastic_pkg.sv | 20 ++
 rtl/pipe_stage_elastic.sv | 128 ++++++++++++
 tb/tb_pipe_stage_elastic.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding and occupancy width.
package pipe_stage_elastic_pkg;

    localparam int PIPE_OCC_W = 2;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_e s);
        case (s)
            PIPE_ONE:  return 2'd1;
            PIPE_FULL: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer and synchronous flush.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter bit SKID           = 1'b1,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    logic                  w_in_fire;
    logic                  w_out_fire;
    pipe_state_e           r_state;
    pipe_state_e           w_state_nxt;
    logic [DATA_W-1:0]     r_main;
    logic [DATA_W-1:0]     w_main_nxt;
    logic                  r_out_valid;
    logic [PIPE_OCC_W-1:0] r_occ;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_main;
    assign occupancy  = r_occ;

    // Valid and occupancy get their own flops so the outputs are never decoded from state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= PIPE_EMPTY;
            r_main      <= '0;
            r_out_valid <= 1'b0;
            r_occ       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_out_valid <= (w_state_nxt != PIPE_EMPTY);
            r_occ       <= occ_of(w_state_nxt);
        end
    end

    if (SKID) begin : g_skid
        logic [DATA_W-1:0] r_skid;
        logic [DATA_W-1:0] w_skid_nxt;
        logic              r_in_ready;

        assign in_ready = r_in_ready;

        always_comb begin
            w_state_nxt = r_state;
            w_main_nxt  = r_main;
            w_skid_nxt  = r_skid;
            case (r_state)
                PIPE_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = PIPE_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                PIPE_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_state_nxt = PIPE_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = PIPE_EMPTY;
                    end
                end
                PIPE_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = PIPE_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = PIPE_EMPTY;
            endcase
            // Flush overrides any transition, including an accepted input beat.
            if (flush) begin
                w_state_nxt = PIPE_EMPTY;
                if (CLEAR_ON_FLUSH) begin
                    w_main_nxt = '0;
                    w_skid_nxt = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_skid     <= '0;
                r_in_ready <= 1'b1;
            end else begin
                r_skid     <= w_skid_nxt;
                r_in_ready <= (w_state_nxt != PIPE_FULL);
            end
        end
    end else begin : g_single
        // Without a skid slot the stage can only accept when the main entry drains this cycle.
        assign in_ready = !r_out_valid | out_ready;

        always_comb begin
            w_state_nxt = r_state;
            w_main_nxt  = r_main;
            if (w_in_fire) begin
                w_state_nxt = PIPE_ONE;
                w_main_nxt  = in_data;
            end else if (w_out_fire) begin
                w_state_nxt = PIPE_EMPTY;
            end
            if (flush) begin
                w_state_nxt = PIPE_EMPTY;
                if (CLEAR_ON_FLUSH) begin
                    w_main_nxt = '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: one skid instance and one single-entry instance, queue scoreboards.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [63:0] in_data1, out_data1;
    logic [1:0]  occ1;
    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [63:0] in_data0, out_data0;
    logic [1:0]  occ0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          beats1   = 0;
    int          beats0   = 0;
    logic [63:0] q1[$];
    logic [63:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(64), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1)) u_skid (
        .clk(clk), .reset(rst), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .occupancy(occ1)
    );

    pipe_stage_elastic #(.DATA_W(64), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b1)) u_single (
        .clk(clk), .reset(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .occupancy(occ0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
    task automatic cycle();
        logic        h1, h0;
        logic [63:0] d1, d0;
        #1;
        if (rst) begin
            q1.delete();
            q0.delete();
        end else begin
            if (out_valid1 && out_ready1) begin
                check("sb1_nonempty", 64'(q1.size() > 0), 64'd1);
                if (q1.size() > 0) check("sb1_data", out_data1, q1.pop_front());
                beats1++;
            end
            if (flush1) q1.delete();
            else if (in_valid1 && in_ready1) q1.push_back(in_data1);
            if (out_valid0 && out_ready0) begin
                check("sb0_nonempty", 64'(q0.size() > 0), 64'd1);
                if (q0.size() > 0) check("sb0_data", out_data0, q0.pop_front());
                beats0++;
            end
            if (flush0) q0.delete();
            else if (in_valid0 && in_ready0) q0.push_back(in_data0);
        end
        h1 = out_valid1 && !out_ready1 && !rst && !flush1;
        h0 = out_valid0 && !out_ready0 && !rst && !flush0;
        d1 = out_data1;
        d0 = out_data0;
        @(posedge clk);
        #1;
        if (h1) begin
            check("hold1_valid", 64'(out_valid1), 64'd1);
            check("hold1_data", out_data1, d1);
        end
        if (h0) begin
            check("hold0_valid", 64'(out_valid0), 64'd1);
            check("hold0_data", out_data0, d0);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        flush1 = 1'b0; in_valid1 = 1'b1; in_data1 = 64'hDEAD; out_ready1 = 1'b0;
        flush0 = 1'b0; in_valid0 = 1'b1; in_data0 = 64'hBEEF; out_ready0 = 1'b0;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0; in_valid1 = 1'b0; in_valid0 = 1'b0;
        check("rst1_out_valid", 64'(out_valid1), 64'd0);
        check("rst1_out_data", out_data1, 64'd0);
        check("rst1_occ", 64'(occ1), 64'd0);
        check("rst1_in_ready", 64'(in_ready1), 64'd1);
        check("rst0_out_valid", 64'(out_valid0), 64'd0);
        check("rst0_in_ready", 64'(in_ready0), 64'd1);

        // Streaming at full rate through both instances
        out_ready1 = 1'b1; out_ready0 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid1 = 1'b1; in_data1 = 64'(i * 'h11);
            in_valid0 = 1'b1; in_data0 = 64'(i * 'h11);
            cycle();
            check("str1_out_valid", 64'(out_valid1), 64'd1);
            check("str1_out_data", out_data1, 64'(i * 'h11));
            check("str1_occ", 64'(occ1), 64'd1);
            check("str1_in_ready", 64'(in_ready1), 64'd1);
            check("str0_out_data", out_data0, 64'(i * 'h11));
            check("str0_in_ready", 64'(in_ready0), 64'd1);
        end
        in_valid1 = 1'b0; in_valid0 = 1'b0;
        cycle();
        check("str1_drained", 64'(out_valid1), 64'd0);
        check("str0_drained", 64'(out_valid0), 64'd0);

        // Skid fill and in-order drain
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = 64'hA1;
        cycle();
        check("skid_occ1", 64'(occ1), 64'd1);
        in_data1 = 64'hA2;
        cycle();
        check("skid_occ2", 64'(occ1), 64'd2);
        check("skid_in_ready", 64'(in_ready1), 64'd0);
        check("skid_head", out_data1, 64'hA1);
        in_data1 = 64'hA3;
        cycle();
        check("skid_still_full", 64'(occ1), 64'd2);
        out_ready1 = 1'b1;
        cycle();
        check("skid_drain_a2", out_data1, 64'hA2);
        check("skid_drain_occ", 64'(occ1), 64'd1);
        check("skid_drain_rdy", 64'(in_ready1), 64'd1);
        cycle();
        check("skid_drain_a3", out_data1, 64'hA3);
        in_valid1 = 1'b0;
        cycle();
        check("skid_empty_q", 64'(q1.size()), 64'd0);
        check("skid_empty_valid", 64'(out_valid1), 64'd0);

        // Flush while full, with a beat offered in the flush cycle
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = 64'hB1;
        cycle();
        in_data1 = 64'hB2;
        cycle();
        check("fl_pre_occ", 64'(occ1), 64'd2);
        flush1 = 1'b1; in_data1 = 64'hFF;
        cycle();
        flush1 = 1'b0; in_valid1 = 1'b0;
        check("fl_occ", 64'(occ1), 64'd0);
        check("fl_out_valid", 64'(out_valid1), 64'd0);
        check("fl_out_data", out_data1, 64'd0);
        check("fl_in_ready", 64'(in_ready1), 64'd1);
        out_ready1 = 1'b1;
        cycle();
        cycle();
        check("fl_no_ff", 64'(out_valid1), 64'd0);

        // Single-entry mode: combinational ready and same-edge replacement
        out_ready0 = 1'b0;
        in_valid0 = 1'b1; in_data0 = 64'h5;
        cycle();
        check("se_hold_data", out_data0, 64'h5);
        in_data0 = 64'h6;
        #1;
        check("se_rdy_low", 64'(in_ready0), 64'd0);
        out_ready0 = 1'b1;
        #1;
        check("se_rdy_comb", 64'(in_ready0), 64'd1);
        cycle();
        check("se_replace", out_data0, 64'h6);
        check("se_valid", 64'(out_valid0), 64'd1);
        in_valid0 = 1'b0;
        cycle();
        check("se_drained", 64'(out_valid0), 64'd0);

        // Reset while full drops everything, including a beat offered during reset
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = 64'hC1;
        cycle();
        in_data1 = 64'hC2;
        cycle();
        check("rf_pre_occ", 64'(occ1), 64'd2);
        rst = 1'b1; in_data1 = 64'hC3;
        cycle();
        rst = 1'b0; in_valid1 = 1'b0;
        check("rf_out_valid", 64'(out_valid1), 64'd0);
        check("rf_occ", 64'(occ1), 64'd0);
        check("rf_out_data", out_data1, 64'd0);
        check("rf_in_ready", 64'(in_ready1), 64'd1);
        out_ready1 = 1'b1;
        cycle();
        cycle();
        check("rf_no_c3", 64'(out_valid1), 64'd0);

        // Random valid/ready backpressure on both instances
        beats1 = 0; beats0 = 0;
        for (int c = 0; c < 60000 && (beats1 < 10000 || beats0 < 10000); c++) begin
            in_valid1  = ($urandom_range(0, 3) != 0);
            in_data1   = {$urandom, $urandom};
            out_ready1 = ($urandom_range(0, 3) != 0);
            in_valid0  = ($urandom_range(0, 3) != 0);
            in_data0   = {$urandom, $urandom};
            out_ready0 = ($urandom_range(0, 3) != 0);
            cycle();
        end
        check("rnd1_beats", 64'(beats1 >= 10000), 64'd1);
        check("rnd0_beats", 64'(beats0 >= 10000), 64'd1);
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        in_valid0 = 1'b0; out_ready0 = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        check("rnd1_q_empty", 64'(q1.size()), 64'd0);
        check("rnd0_q_empty", 64'(q0.size()), 64'd0);
        check("rnd1_idle", 64'(out_valid1), 64'd0);
        check("rnd0_idle", 64'(out_valid0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
